// File: rtl/bin_to_bcd_converter_if.sv
// Handshake and result bundle between the tally logic, the converter and the display driver.
// The master side issues start/binary requests and reads back the BCD digits.
interface bin_to_bcd_converter_if #(
  parameter int BIN_WIDTH = 14
);
  logic                 start;
  logic [BIN_WIDTH-1:0] binary;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [3:0]           ones;
  logic [3:0]           tens;
  logic [3:0]           hundreds;
  logic [3:0]           thousands;

  modport master (
    output start, binary,
    input  busy, done, overflow, ones, tens, hundreds, thousands
  );

  modport slave (
    input  start, binary,
    output busy, done, overflow, ones, tens, hundreds, thousands
  );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: 14-bit vote tally to four saturated BCD digits.
// Digits and overflow only update on the edge that raises done, so the display never sees partial values.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one adjust-and-shift step per clock, 14 steps per conversion
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  bin_to_bcd_converter_if.slave  bus
);

  localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_VALUE);
  localparam logic [3:0]           LAST_BIT = 4'(BIN_WIDTH - 1);
  localparam int                   WORD_W   = 16 + BIN_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [15:0]          bcd_reg;
  logic [3:0]           bit_cnt;
  logic                 overflow_pending;

  logic                 busy_r;
  logic                 done_r;
  logic                 overflow_r;
  logic [15:0]          digits_r;

  logic [15:0]          bcd_adj;
  logic [WORD_W-1:0]    shift_word;
  logic [WORD_W-1:0]    shifted;
  logic [15:0]          bcd_next;
  logic [BIN_WIDTH-1:0] bin_next;

  // Add-3 on each nibble >= 5; a nibble never exceeds 9 here, so no inter-nibble carry.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < 4; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
      end
    end
    shift_word = {bcd_adj, shift_reg};
    shifted    = shift_word << 1;
    bcd_next   = shifted[WORD_W-1:BIN_WIDTH];
    bin_next   = shifted[BIN_WIDTH-1:0];
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      shift_reg        <= '0;
      bcd_reg          <= '0;
      bit_cnt          <= '0;
      overflow_pending <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      overflow_r       <= 1'b0;
      digits_r         <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg        <= (bus.binary > MAX_BIN) ? MAX_BIN : bus.binary;
            overflow_pending <= (bus.binary > MAX_BIN);
            bcd_reg          <= '0;
            bit_cnt          <= '0;
            busy_r           <= 1'b1;
            state            <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg   <= bcd_next;
          shift_reg <= bin_next;
          bit_cnt   <= bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            digits_r   <= bcd_next;
            overflow_r <= overflow_pending;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.overflow  = overflow_r;
  assign bus.ones      = digits_r[3:0];
  assign bus.tens      = digits_r[7:4];
  assign bus.hundreds  = digits_r[11:8];
  assign bus.thousands = digits_r[15:12];

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: expected digits are queued at start-accept
// and compared against each done pulse, together with latency and overflow.
module tb_bin_to_bcd_converter;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;

  bin_to_bcd_converter_if #(.BIN_WIDTH(14)) bus ();

  bin_to_bcd_converter #(.BIN_WIDTH(14), .MAX_VALUE(9999)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [15:0] dig;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   passed   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   n_push   = 0;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    int   s;
    s       = (v > 9999) ? 9999 : v;
    e.dig   = {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    e.ovf   = (v > 9999);
    e.acc   = acc;
    return e;
  endfunction

  task automatic push(input int v);
    sb.push_back(model(v, cyc));
    n_push++;
  endtask

  // Single-cycle start pulse; returns at the negedge following the accept edge.
  task automatic convert(input int v);
    @(negedge clk_100MHz);
    bus.start  = 1'b1;
    bus.binary = 14'(v);
    @(posedge clk_100MHz);
    #1;
    push(v);
    @(negedge clk_100MHz);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 40) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("idle_timeout", sb.size(), 0);
  endtask

  always @(negedge clk_100MHz) begin
    if (!reset && bus.done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("digits", {bus.thousands, bus.hundreds, bus.tens, bus.ones}, e.dig);
        check("overflow", bus.overflow, e.ovf);
        check("latency", cyc - e.acc, 14);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int d1;
    int d2;
    bit stable;
    int n;

    bus.start  = 1'b0;
    bus.binary = '0;
    repeat (3) @(negedge clk_100MHz);
    check("reset_outputs",
          {bus.busy, bus.done, bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.ones}, 0);
    reset = 1'b0;
    @(negedge clk_100MHz);

    // zero, with busy width measured around it
    convert(0);
    bc = int'(bus.busy);
    repeat (19) begin
      @(negedge clk_100MHz);
      bc += int'(bus.busy);
    end
    check("busy_cycles", bc, 14);
    wait_idle();

    convert(1234);  wait_idle();
    convert(9999);  wait_idle();
    convert(5);     wait_idle();
    convert(10000); wait_idle();
    convert(16383); wait_idle();
    convert(42);    wait_idle();

    // start during SHIFT must be ignored
    convert(777);
    repeat (4) @(negedge clk_100MHz);
    bus.start  = 1'b1;
    bus.binary = 14'd3;
    @(negedge clk_100MHz);
    bus.start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk_100MHz);
    check("busy_ignore_done_count", done_cnt, n_push);
    check("busy_ignore_idle", bus.busy, 0);

    // back-to-back with start held high
    @(negedge clk_100MHz);
    bus.start  = 1'b1;
    bus.binary = 14'd1;
    @(posedge clk_100MHz);
    #1;
    push(1);
    n  = 0;
    d1 = 0;
    while (n < 30) begin
      @(negedge clk_100MHz);
      n++;
      if (bus.done) begin
        d1 = cyc;
        break;
      end
    end
    bus.binary = 14'd2048;
    @(posedge clk_100MHz);
    #1;
    push(2048);
    stable = 1'b1;
    n      = 0;
    d2     = 0;
    while (n < 30) begin
      @(negedge clk_100MHz);
      n++;
      if (bus.done) begin
        d2        = cyc;
        bus.start = 1'b0;
        break;
      end else if ({bus.thousands, bus.hundreds, bus.tens, bus.ones} !== 16'h0001) begin
        stable = 1'b0;
      end
    end
    bus.start = 1'b0;
    check("b2b_spacing", d2 - d1, 15);
    check("b2b_hold", stable, 1);
    wait_idle();
    check("b2b_done_count", done_cnt, n_push);

    // reset mid-conversion
    @(negedge clk_100MHz);
    bus.start  = 1'b1;
    bus.binary = 14'd4321;
    @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    bus.start = 1'b0;
    repeat (7) @(posedge clk_100MHz);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_outputs",
          {bus.busy, bus.done, bus.overflow, bus.thousands, bus.hundreds, bus.tens, bus.ones}, 0);
    repeat (2) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (20) @(negedge clk_100MHz);
    check("reset_no_done", done_cnt, n_push);
    convert(4321);
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
